// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier sequencer: drives the shared ALU while busy to form the low WIDTH bits of op_a*op_b.
// Optional EARLY_EXIT_EN: leave the iteration loop as soon as no multiplier bits remain.
module alu_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [3:0]       CTL_ADD  = 4'b0010;
    localparam logic [3:0]       CTL_SLL  = 4'b1000;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             last_iter;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctl   = CTL_ADD;
        busy      = 1'b0;
        done      = 1'b0;
        last_iter = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    mcand_d = op_a;
                    mplr_d  = op_b;
                    cnt_d   = '0;
                    state_d = op_b[0] ? S_ADD : S_SHIFT;
                end
            end
            S_ADD: begin
                busy    = 1'b1;
                alu_a   = acc_q;
                alu_b   = mcand_q;
                alu_ctl = CTL_ADD;
                acc_d   = alu_result;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy      = 1'b1;
                alu_a     = mcand_q;
                alu_b     = WIDTH'(1);
                alu_ctl   = CTL_SLL;
                mcand_d   = alu_result;
                mplr_d    = mplr_q >> 1;
                cnt_d     = cnt_q + CNT_W'(1);
                last_iter = (cnt_q == LAST_CNT);
`ifdef EARLY_EXIT_EN
                if (mplr_q[WIDTH-1:1] == '0) begin
                    last_iter = 1'b1;
                end
`endif
                // acc is final once the last shift is reached, so product is valid during DONE.
                if (last_iter) begin
                    state_d   = S_DONE;
                    product_d = acc_q;
                end else begin
                    state_d = mplr_q[1] ? S_ADD : S_SHIFT;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign product = product_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: table vectors, ignored-start and abort sequences, random operands.
module tb_alu_mul_sequencer;

    localparam int WIDTH = 32;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SLL = 4'b1000;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] op_a, op_b;
    logic             busy, done;
    logic [WIDTH-1:0] product, alu_a, alu_b, alu_result;
    logic [3:0]       alu_ctl;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctl    (alu_ctl),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    // Shared ALU as seen by the sequencer.
    always_comb begin
        case (alu_ctl)
            CTL_ADD: alu_result = alu_a + alu_b;
            CTL_SLL: alu_result = alu_a << alu_b[4:0];
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int highest_bit(input logic [WIDTH-1:0] b);
        int hi = -1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) hi = i;
        return hi;
    endfunction

    // Busy-cycle count derived from the multiplier bits.
    function automatic int model_busy(input logic [WIDTH-1:0] b);
`ifdef EARLY_EXIT_EN
        int hi = highest_bit(b);
        int zeros = 0;
        if (b == 0) return 1;
        for (int i = 0; i < hi; i++) if (!b[i]) zeros++;
        return 2 * (hi + 1) - zeros;
`else
        return WIDTH + $countones(b);
`endif
    endfunction

    function automatic logic [WIDTH-1:0] model_product(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] full;
        full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return full[WIDTH-1:0];
    endfunction

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_p;
    } vec_t;

    // Runs one multiplication. inject: pulse start (7*7) at busy cycles 3 and 10 and in the done cycle.
    // abort_at: nonzero asserts reset asynchronously in that cycle and checks the abort.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_p, input bit inject, input int abort_at);
        logic [3:0] got_q[$];
        logic [3:0] exp_q[$];
        int lat = model_busy(b);
        int iters;
        int busy_cnt = 0;
        int done_k = 0;
        int seq_err = -1;
        int done_seen = 0;
        iters = WIDTH;
`ifdef EARLY_EXIT_EN
        iters = (b == 0) ? 1 : highest_bit(b) + 1;
`endif
        for (int i = 0; i < iters; i++) begin
            if (b[i]) exp_q.push_back(CTL_ADD);
            exp_q.push_back(CTL_SLL);
        end

        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        for (int k = 1; k <= 4 * WIDTH; k++) begin
            if (busy) begin
                busy_cnt++;
                got_q.push_back(alu_ctl);
            end
            if (abort_at == k) begin
                #2 reset = 1'b1;
                #1;
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                check("abort_product", 64'(product), 64'd0);
                check("abort_alu_a", 64'(alu_a), 64'd0);
                check("abort_alu_ctl", 64'(alu_ctl), 64'(CTL_ADD));
                @(negedge clk);
                reset = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    if (done || busy) done_seen++;
                    @(negedge clk);
                end
                check("abort_no_done", 64'(done_seen), 64'd0);
                return;
            end
            if (done) begin
                done_k = k;
                check("product_in_done", 64'(product), 64'(exp_p));
                start = inject;
                break;
            end
            start = inject && (k == 3 || k == 10);
            if (start) begin
                op_a = 7; op_b = 7;
            end
            @(negedge clk);
        end

        check("done_cycle", 64'(done_k), 64'(lat + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(lat));
        if (got_q.size() != exp_q.size()) seq_err = 999;
        else foreach (exp_q[i]) if (seq_err < 0 && got_q[i] !== exp_q[i]) seq_err = i;
        check("alu_ctl_seq", 64'(seq_err), 64'(-1));

        @(negedge clk);
        start = 1'b0;
        check("done_one_pulse", 64'(done), 64'd0);
        check("product_hold", 64'(product), 64'(exp_p));
        if (inject) begin
            @(negedge clk);
            check("start_in_done_ignored", 64'(busy), 64'd0);
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 32'd3,          b: 32'd5,          exp_p: 32'd15};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp_p: 32'h0000_0001};
        vecs[2] = '{a: 32'h1234_5678,  b: 32'd0,          exp_p: 32'd0};
        vecs[3] = '{a: 32'd6,          b: 32'd7,          exp_p: 32'd42};
        vecs[4] = '{a: 32'd1,          b: 32'h8000_0000,  exp_p: 32'h8000_0000};
        vecs[5] = '{a: 32'h0000_FFFF,  b: 32'h0000_FFFF,  exp_p: 32'hFFFE_0001};

        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        check("reset_alu_b", 64'(alu_b), 64'd0);
        check("reset_alu_ctl", 64'(alu_ctl), 64'(CTL_ADD));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_start", 64'(busy), 64'd0);

        for (int i = 0; i < 6; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp_p, 1'b0, 0);

        // Starts while busy and in DONE are ignored; the next real start then runs normally.
        run_op(32'd3, 32'd5, 32'd15, 1'b1, 0);
        run_op(32'd7, 32'd7, 32'd49, 1'b0, 0);

        // Abort mid-operation, then recover.
        run_op(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 10);
        run_op(32'd6, 32'd7, 32'd42, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = $urandom;
            rb = (i < 4) ? WIDTH'($urandom_range(0, 255)) : $urandom;
            run_op(ra, rb, model_product(ra, rb), 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
